// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the sequencer state encoding, the ALU function-select codes and the default program depth.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam logic [2:0] SEL_INC    = 3'b000;
    localparam logic [2:0] SEL_ADD_RA = 3'b001;
    localparam logic [2:0] SEL_ADD    = 3'b010;
    localparam logic [2:0] SEL_ORXOR  = 3'b011;
    localparam logic [2:0] SEL_ANYOR  = 3'b100;
    localparam logic [2:0] SEL_SHL    = 3'b101;
    localparam logic [2:0] SEL_SHR    = 3'b110;
    localparam logic [2:0] SEL_MUL    = 3'b111;

    localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/seq_buffer.sv
// Program storage for the sequencer.
// A register array with one synchronous write port and one combinational read port.
module seq_buffer #(
    parameter int DEPTH = 8,
    parameter int W     = 7
) (
    input  logic                     i_clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
    input  logic [W-1:0]             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [W-1:0]             o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    // Contents are not reset; the top only reads indices below its entry count.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers a short program of (select, operand) pairs and replays them to the ALU one entry per step.
// Each issued entry is registered onto the ALU inputs together with a one-cycle issue strobe.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SEL_W = 3,
    parameter int A_W   = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_clr,
    input  logic                       i_wr_en,
    input  logic [SEL_W-1:0]           i_wr_sel,
    input  logic [A_W-1:0]             i_wr_a,
    input  logic                       i_start,
    input  logic                       i_step,
    output logic [SEL_W-1:0]           o_alu_sel,
    output logic [A_W-1:0]             o_alu_a,
    output logic                       o_issue,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SEL_W + A_W;

    seq_state_t         r_state;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [SEL_W-1:0]   r_alu_sel;
    logic [A_W-1:0]     r_alu_a;
    logic               r_issue;

    logic               w_full;
    logic               w_wr_fire;
    logic               w_last;
    logic [ENT_W-1:0]   w_rd_data;

    assign w_full = (r_count == CNT_W'(DEPTH));

    // A write only lands in LOAD when nothing of higher priority is asserted and there is room.
    assign w_wr_fire = (r_state == ST_LOAD) && i_wr_en && !i_reset && !i_clr && !i_start && !w_full;

    assign w_last = ({1'b0, r_rd_ptr} == (r_count - CNT_W'(1)));

    seq_buffer #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_buffer (
        .i_clock   (i_clock),
        .i_wr_en   (w_wr_fire),
        .i_wr_idx  (r_count[PTR_W-1:0]),
        .i_wr_data ({i_wr_sel, i_wr_a}),
        .i_rd_idx  (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_LOAD;
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_alu_sel <= '0;
            r_alu_a   <= '0;
            r_issue   <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            if (i_clr) begin
                r_state  <= ST_LOAD;
                r_count  <= '0;
                r_rd_ptr <= '0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (i_start) begin
                            if (r_count != '0) begin
                                r_rd_ptr <= '0;
                                r_state  <= ST_RUN;
                            end
                        end else if (w_wr_fire) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (i_step) begin
                            r_alu_sel <= w_rd_data[ENT_W-1:A_W];
                            r_alu_a   <= w_rd_data[A_W-1:0];
                            r_issue   <= 1'b1;
                            // The pointer parks on the final entry so it never reaches count.
                            if (w_last) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (i_start) begin
                            r_rd_ptr <= '0;
                            r_state  <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

    assign o_alu_sel = r_alu_sel;
    assign o_alu_a   = r_alu_a;
    assign o_issue   = r_issue;
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_busy    = (r_state == ST_RUN);
    assign o_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with DEPTH=8.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_alu_op_sequencer;

    logic       clock;
    logic       reset;
    logic       clr;
    logic       wrEn;
    logic [2:0] wrSel;
    logic [3:0] wrA;
    logic       start;
    logic       step;
    logic [2:0] aluSel;
    logic [3:0] aluA;
    logic       issue;
    logic [3:0] count;
    logic       full;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(
        .DEPTH (8),
        .SEL_W (3),
        .A_W   (4)
    ) dut (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_clr     (clr),
        .i_wr_en   (wrEn),
        .i_wr_sel  (wrSel),
        .i_wr_a    (wrA),
        .i_start   (start),
        .i_step    (step),
        .o_alu_sel (aluSel),
        .o_alu_a   (aluA),
        .o_issue   (issue),
        .o_count   (count),
        .o_full    (full),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        reset = 1'b0; clr = 1'b0; wrEn = 1'b0; wrSel = '0; wrA = '0; start = 1'b0; step = 1'b0;
    endtask

    task automatic writeEntry(input logic [2:0] s, input logic [3:0] a);
        wrEn = 1'b1; wrSel = s; wrA = a;
        tick();
        wrEn = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (aluSel !== 3'd0) begin errors++; $display("[TB] FAIL reset_sel got %0d expected 0", aluSel); end
        checks++; if (aluA !== 4'd0) begin errors++; $display("[TB] FAIL reset_a got %0d expected 0", aluA); end
        checks++; if (issue !== 1'b0) begin errors++; $display("[TB] FAIL reset_issue got %b expected 0", issue); end
        checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
        checks++; if ({full, busy, done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 000", {full, busy, done}); end
    endtask

    // Program (001,3) (101,1) (111,2), then three back-to-back steps.
    task automatic test_back_to_back();
        logic [2:0] expSel [3];
        logic [3:0] expA [3];
        expSel[0] = 3'b001; expA[0] = 4'd3;
        expSel[1] = 3'b101; expA[1] = 4'd1;
        expSel[2] = 3'b111; expA[2] = 4'd2;
        for (int i = 0; i < 3; i++) begin
            writeEntry(expSel[i], expA[i]);
            checks++; if (count !== 4'(i + 1)) begin errors++; $display("[TB] FAIL b2b_count got %0d expected %0d", count, i + 1); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, done, issue} !== 3'b100) begin errors++; $display("[TB] FAIL b2b_start got %b expected 100", {busy, done, issue}); end
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({issue, aluSel, aluA} !== {1'b1, expSel[i], expA[i]}) begin errors++; $display("[TB] FAIL b2b_issue%0d got %b/%0d/%0d expected 1/%0d/%0d", i, issue, aluSel, aluA, expSel[i], expA[i]); end
            checks++; if ({busy, done} !== ((i == 2) ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL b2b_state%0d got %b", i, {busy, done}); end
        end
        step = 1'b0;
        tick();
        checks++; if ({issue, aluSel, aluA, done} !== {1'b0, 3'b111, 4'd2, 1'b1}) begin errors++; $display("[TB] FAIL b2b_hold got %b/%0d/%0d/%b expected 0/7/2/1", issue, aluSel, aluA, done); end
    endtask

    // Starts in DONE holding the three-entry program.
    task automatic test_replay();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, done, issue} !== 3'b100) begin errors++; $display("[TB] FAIL replay_start got %b expected 100", {busy, done, issue}); end
        step = 1'b1;
        tick();
        checks++; if ({issue, aluSel, aluA} !== {1'b1, 3'b001, 4'd3}) begin errors++; $display("[TB] FAIL replay_e0 got %b/%0d/%0d expected 1/1/3", issue, aluSel, aluA); end
        tick();
        checks++; if ({issue, aluSel, aluA} !== {1'b1, 3'b101, 4'd1}) begin errors++; $display("[TB] FAIL replay_e1 got %b/%0d/%0d expected 1/5/1", issue, aluSel, aluA); end
        tick();
        step = 1'b0;
        checks++; if ({issue, done} !== 2'b11) begin errors++; $display("[TB] FAIL replay_last got %b expected 11", {issue, done}); end
        writeEntry(3'd4, 4'd9);
        checks++; if ({count, done} !== {4'd3, 1'b1}) begin errors++; $display("[TB] FAIL done_write got %0d/%b expected 3/1", count, done); end
    endtask

    task automatic test_clr_start();
        clr = 1'b1; start = 1'b1;
        tick();
        clr = 1'b0; start = 1'b0;
        checks++; if ({count, busy, done, issue} !== {4'd0, 3'b000}) begin errors++; $display("[TB] FAIL clr_start got %0d/%b expected 0/000", count, {busy, done, issue}); end
    endtask

    task automatic test_start_empty();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, done, issue} !== 3'b000) begin errors++; $display("[TB] FAIL empty_start got %b expected 000", {busy, done, issue}); end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (issue !== 1'b0) begin errors++; $display("[TB] FAIL load_step got %b expected 0", issue); end
    endtask

    task automatic test_start_with_write();
        writeEntry(3'b010, 4'd6);
        writeEntry(3'b110, 4'd12);
        start = 1'b1; wrEn = 1'b1; wrSel = 3'b011; wrA = 4'd15;
        tick();
        start = 1'b0; wrEn = 1'b0;
        checks++; if ({count, busy} !== {4'd2, 1'b1}) begin errors++; $display("[TB] FAIL start_wr got %0d/%b expected 2/1", count, busy); end
        step = 1'b1;
        tick();
        checks++; if ({issue, aluSel, aluA} !== {1'b1, 3'b010, 4'd6}) begin errors++; $display("[TB] FAIL start_wr_e0 got %b/%0d/%0d expected 1/2/6", issue, aluSel, aluA); end
        tick();
        step = 1'b0;
        checks++; if ({issue, aluSel, aluA, done} !== {1'b1, 3'b110, 4'd12, 1'b1}) begin errors++; $display("[TB] FAIL start_wr_e1 got %b/%0d/%0d/%b expected 1/6/12/1", issue, aluSel, aluA, done); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Nine writes into an eight-entry buffer; entry i holds (i[2:0], i+4).
    task automatic test_full();
        for (int i = 0; i < 9; i++) begin
            writeEntry(3'(i), 4'(i + 4));
            if (i >= 7) begin
                checks++; if ({count, full} !== {4'd8, 1'b1}) begin errors++; $display("[TB] FAIL full_w%0d got %0d/%b expected 8/1", i, count, full); end
            end else begin
                checks++; if ({count, full} !== {4'(i + 1), 1'b0}) begin errors++; $display("[TB] FAIL fill_w%0d got %0d/%b expected %0d/0", i, count, full, i + 1); end
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        step = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if ({issue, aluSel, aluA, done} !== {1'b1, 3'(i), 4'(i + 4), (i == 7)}) begin errors++; $display("[TB] FAIL full_run%0d got %b/%0d/%0d/%b", i, issue, aluSel, aluA, done); end
        end
        tick();
        step = 1'b0;
        checks++; if ({issue, aluSel, aluA} !== {1'b0, 3'd7, 4'd11}) begin errors++; $display("[TB] FAIL full_extra got %b/%0d/%0d expected 0/7/11", issue, aluSel, aluA); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        writeEntry(3'b100, 4'd5);
        writeEntry(3'b011, 4'd7);
        writeEntry(3'b000, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        step = 1'b1;
        tick();
        checks++; if ({issue, aluSel, aluA} !== {1'b1, 3'b100, 4'd5}) begin errors++; $display("[TB] FAIL mid_e0 got %b/%0d/%0d expected 1/4/5", issue, aluSel, aluA); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({aluSel, aluA, issue, count, full, busy, done} !== 15'd0) begin errors++; $display("[TB] FAIL mid_reset got %0d/%0d/%b/%0d/%b%b%b expected all 0", aluSel, aluA, issue, count, full, busy, done); end
        tick();
        step = 1'b0;
        checks++; if ({issue, busy} !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_step got %b expected 00", {issue, busy}); end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_back_to_back();
        test_replay();
        test_clr_start();
        test_start_empty();
        test_start_with_write();
        test_full();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
